// File: rtl/nonce_tx_queue.sv
// nonce_tx_queue
//
// Result queue in the comm clock domain. It sits between the hashing core's
// ticket output and the serial core's transmit side. Golden nonces are held in
// a small circular buffer. A nonce that repeats the last accepted one is
// dropped. Queued nonces are handed to the UART one at a time using a
// send/busy handshake. A nonce is lost only when it arrives while the queue is
// full and nothing leaves in the same cycle; each such loss is counted.
//
// Parameters
//   DEPTH         queue entries (power of two, >= 2)
//   BUSY_TIMEOUT  cycles to wait for tx_busy to rise after tx_send
//
// Ports
//   clk           comm clock
//   rst           asynchronous, active-high reset
//   nonce_valid   one-cycle strobe: nonce_in holds a found nonce
//   nonce_in      nonce value
//   flush         new job started; discard queued nonces
//   tx_busy       serial core transmitting
//   tx_send       one-cycle strobe to serial core: send tx_word
//   tx_word       nonce presented to serial core (held until the next pop)
//   queue_count   entries currently stored
//   queue_empty   queue_count == 0
//   overflow_cnt  nonces dropped because the queue was full; saturates at 255

module nonce_tx_queue #(
   parameter int unsigned DEPTH        = 4,
   parameter int unsigned BUSY_TIMEOUT = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     nonce_valid,
   input  logic [31:0]              nonce_in,
   input  logic                     flush,
   input  logic                     tx_busy,
   output logic                     tx_send,
   output logic [31:0]              tx_word,
   output logic [$clog2(DEPTH):0]   queue_count,
   output logic                     queue_empty,
   output logic [7:0]               overflow_cnt
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = PtrW + 1;
   // One extra value of headroom so BUSY_TIMEOUT == 1 still gets a 1-bit timer.
   localparam int unsigned TmrW = $clog2(BUSY_TIMEOUT + 1);

   localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);
   localparam logic [TmrW-1:0] TmrLast = TmrW'(BUSY_TIMEOUT - 1);

   typedef enum logic [1:0] {
      StIdle,
      StSend,
      StWaitBusy,
      StWaitIdle
   } state_e;

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   logic [31:0]     mem_q [DEPTH];
   logic [PtrW-1:0] rd_ptr_q;
   logic [PtrW-1:0] wr_ptr_q;
   logic [CntW-1:0] count_q;
   logic [31:0]     last_nonce_q;
   logic            last_valid_q;
   logic [7:0]      ovf_q;

   state_e          state_q;
   logic [TmrW-1:0] timer_q;
   logic            tx_send_q;
   logic [31:0]     tx_word_q;

   // ---------------------------------------------------------------------------
   // Push / pop decisions
   // ---------------------------------------------------------------------------
   logic pop;
   logic is_dup;
   logic offer;
   logic push;
   logic drop;

   always_comb begin
      // The sender takes the head only from IDLE. A flush in the same cycle
      // holds it back so that no stale nonce leaves after a job change.
      pop    = (state_q == StIdle) && (count_q != '0) && !tx_busy && !flush;
      is_dup = last_valid_q && (nonce_in == last_nonce_q);
      offer  = nonce_valid && !flush && !is_dup;
      // At full, a push is still accepted when the head leaves in the same cycle.
      push   = offer && ((count_q != CntFull) || pop);
      drop   = offer && !push;
   end

   // ---------------------------------------------------------------------------
   // Queue storage. The data array is not reset: every entry is written before
   // it can be read.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= nonce_in;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr_q     <= '0;
         wr_ptr_q     <= '0;
         count_q      <= '0;
         last_nonce_q <= '0;
         last_valid_q <= 1'b0;
         ovf_q        <= '0;
      end else begin
         if (flush) begin
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            last_valid_q <= 1'b0;
         end else begin
            // Pointers are PtrW bits wide and DEPTH is a power of two, so they
            // wrap from DEPTH-1 to 0 on their own.
            if (push) begin
               wr_ptr_q     <= wr_ptr_q + 1'b1;
               last_nonce_q <= nonce_in;
               last_valid_q <= 1'b1;
            end
            if (pop) begin
               rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
               count_q <= count_q + 1'b1;
            end else if (pop && !push) begin
               count_q <= count_q - 1'b1;
            end
         end
         // Only resets clear the overflow counter; flush leaves it unchanged.
         if (drop && (ovf_q != 8'hFF)) begin
            ovf_q <= ovf_q + 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Transmit handshake FSM. Flush does not affect it: a word that has already
   // been handed off completes normally.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StIdle;
         timer_q   <= '0;
         tx_send_q <= 1'b0;
         tx_word_q <= '0;
      end else begin
         tx_send_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (pop) begin
                  tx_word_q <= mem_q[rd_ptr_q];
                  tx_send_q <= 1'b1;
                  state_q   <= StSend;
               end
            end
            StSend: begin
               timer_q <= '0;
               state_q <= StWaitBusy;
            end
            StWaitBusy: begin
               if (tx_busy) begin
                  state_q <= StWaitIdle;
               end else if (timer_q == TmrLast) begin
                  // The UART never acknowledged the word; treat it as sent
                  // so the queue does not stall.
                  state_q <= StIdle;
               end else begin
                  timer_q <= timer_q + 1'b1;
               end
            end
            StWaitIdle: begin
               if (!tx_busy) begin
                  state_q <= StIdle;
               end
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign tx_send      = tx_send_q;
   assign tx_word      = tx_word_q;
   assign queue_count  = count_q;
   assign queue_empty  = (count_q == '0);
   assign overflow_cnt = ovf_q;

   // ---------------------------------------------------------------------------
   // Invariants
   // ---------------------------------------------------------------------------
   a_count_bound : assert property (@(posedge clk) disable iff (rst) count_q <= CntFull);
   a_send_pulse  : assert property (@(posedge clk) disable iff (rst) tx_send_q |=> !tx_send_q);

endmodule

// File: tb/tb_nonce_tx_queue.sv
module tb_nonce_tx_queue;

   localparam int Depth   = 4;
   localparam int Timeout = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        nonce_valid = 1'b0;
   logic [31:0] nonce_in = '0;
   logic        flush = 1'b0;
   logic        tx_busy = 1'b0;
   logic        tx_send;
   logic [31:0] tx_word;
   logic [2:0]  queue_count;
   logic        queue_empty;
   logic [7:0]  overflow_cnt;

   int errors = 0;
   int checks = 0;

   nonce_tx_queue #(
      .DEPTH       (Depth),
      .BUSY_TIMEOUT(Timeout)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .nonce_valid (nonce_valid),
      .nonce_in    (nonce_in),
      .flush       (flush),
      .tx_busy     (tx_busy),
      .tx_send     (tx_send),
      .tx_word     (tx_word),
      .queue_count (queue_count),
      .queue_empty (queue_empty),
      .overflow_cnt(overflow_cnt)
   );

   always #5 clk = ~clk;

   function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endfunction

   // ---------------------------------------------------------------------------
   // Reference model: a plain FIFO of accepted nonces, plus the sender's
   // handoff phase (0 ready, 1 strobing, 2 awaiting busy, 3 awaiting idle).
   // ---------------------------------------------------------------------------
   logic [31:0] mq[$];
   logic [31:0] m_last = '0;
   bit          m_lv = 1'b0;
   int          m_ovf = 0;
   int          m_phase = 0;
   int          m_tmr = 0;
   logic [31:0] m_word = '0;
   bit          m_send = 1'b0;
   int          m_sz;
   bit          m_take;
   bit          m_new;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mq.delete();
         m_last  = '0;
         m_lv    = 1'b0;
         m_ovf   = 0;
         m_phase = 0;
         m_tmr   = 0;
         m_word  = '0;
         m_send  = 1'b0;
      end else begin
         m_sz   = mq.size();
         m_take = (m_phase == 0) && (m_sz > 0) && !tx_busy && !flush;
         m_new  = nonce_valid && !flush && !(m_lv && nonce_in == m_last);
         if (m_new && m_sz == Depth && !m_take && m_ovf < 255) m_ovf++;
         m_send = m_take;
         case (m_phase)
            0: if (m_take) m_phase = 1;
            1: begin m_phase = 2; m_tmr = 0; end
            2: begin
               if (tx_busy) m_phase = 3;
               else if (m_tmr == Timeout - 1) m_phase = 0;
               else m_tmr++;
            end
            default: if (!tx_busy) m_phase = 0;
         endcase
         if (flush) begin
            mq.delete();
            m_lv = 1'b0;
         end else begin
            if (m_take) m_word = mq.pop_front();
            if (m_new && (m_sz < Depth || m_take)) begin
               mq.push_back(nonce_in);
               m_last = nonce_in;
               m_lv   = 1'b1;
            end
         end
      end
   end

   always @(negedge clk) begin
      check("cmp_send", {31'd0, tx_send}, {31'd0, m_send});
      check("cmp_word", tx_word, m_word);
      check("cmp_count", {29'd0, queue_count}, mq.size());
      check("cmp_empty", {31'd0, queue_empty}, {31'd0, mq.size() == 0});
      check("cmp_ovf", {24'd0, overflow_cnt}, m_ovf);
   end

   // ---------------------------------------------------------------------------
   // Stimulus helpers
   // ---------------------------------------------------------------------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [31:0] v);
      nonce_valid = 1'b1;
      nonce_in    = v;
      tick();
      nonce_valid = 1'b0;
   endtask

   task automatic wait_send(output int cyc);
      cyc = 0;
      while (tx_send !== 1'b1 && cyc < 64) begin
         tick();
         cyc++;
      end
      check("send_seen", {31'd0, tx_send}, 32'd1);
   endtask

   // Plays the UART: accept one word, be busy two cycles, go idle.
   task automatic serve(input logic [31:0] w);
      int c;
      wait_send(c);
      check("serve_word", tx_word, w);
      tx_busy = 1'b1;
      tick();
      tick();
      tx_busy = 1'b0;
      tick();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int c;

      // Reset
      tick();
      tick();
      check("rst_empty", {31'd0, queue_empty}, 32'd1);
      check("rst_send", {31'd0, tx_send}, 32'd0);
      check("rst_count", {29'd0, queue_count}, 32'd0);
      check("rst_word", tx_word, 32'd0);
      #2 rst = 1'b0;
      tick();

      // 1: single nonce, latency N+1 count, N+2 send
      push(32'hDEADBEEF);
      check("t1_count_n1", {29'd0, queue_count}, 32'd1);
      tick();
      check("t1_send_n2", {31'd0, tx_send}, 32'd1);
      check("t1_word_n2", tx_word, 32'hDEADBEEF);
      tx_busy = 1'b1;
      tick();
      check("t1_send_pulse", {31'd0, tx_send}, 32'd0);
      tick();
      tick();
      tx_busy = 1'b0;
      tick();
      tick();
      check("t1_empty", {31'd0, queue_empty}, 32'd1);

      // 2: overflow under busy, then in-order drain
      tx_busy = 1'b1;
      for (int i = 1; i <= 6; i++) push(32'h1000_0000 + i);
      check("t2_count", {29'd0, queue_count}, 32'd4);
      check("t2_ovf", {24'd0, overflow_cnt}, 32'd2);
      tx_busy = 1'b0;
      for (int i = 1; i <= 4; i++) serve(32'h1000_0000 + i);
      check("t2_drained", {31'd0, queue_empty}, 32'd1);

      // 3: duplicate suppression against last accepted only
      tx_busy = 1'b1;
      push(32'h0000_1234);
      push(32'h0000_1234);
      check("t3_dup_count", {29'd0, queue_count}, 32'd1);
      push(32'h0000_5678);
      push(32'h0000_1234);
      check("t3_count", {29'd0, queue_count}, 32'd3);
      check("t3_ovf", {24'd0, overflow_cnt}, 32'd2);
      tx_busy = 1'b0;
      serve(32'h0000_1234);
      serve(32'h0000_5678);
      serve(32'h0000_1234);

      // 4: flush beats a same-cycle push and clears last_valid
      tx_busy = 1'b1;
      push(32'h0000_1111);
      push(32'h0000_2222);
      push(32'h0000_1234);
      flush       = 1'b1;
      nonce_valid = 1'b1;
      nonce_in    = 32'hAAAA0000;
      tick();
      flush       = 1'b0;
      nonce_valid = 1'b0;
      check("t4_count", {29'd0, queue_count}, 32'd0);
      check("t4_ovf", {24'd0, overflow_cnt}, 32'd2);
      check("t4_nosend", {31'd0, tx_send}, 32'd0);
      push(32'h0000_1234);
      check("t4_relast", {29'd0, queue_count}, 32'd1);
      tx_busy = 1'b0;
      serve(32'h0000_1234);

      // 5: busy timeout, next send BUSY_TIMEOUT+2 cycles after the first
      tx_busy = 1'b1;
      push(32'hCAFE0001);
      push(32'hCAFE0002);
      tx_busy = 1'b0;
      wait_send(c);
      check("t5_word1", tx_word, 32'hCAFE0001);
      tick();
      wait_send(c);
      check("t5_gap", c + 1, 32'd18);
      check("t5_word2", tx_word, 32'hCAFE0002);
      tx_busy = 1'b1;
      tick();
      tick();
      tx_busy = 1'b0;
      tick();

      // 6: reset during WAIT_IDLE with two entries queued
      tx_busy = 1'b1;
      push(32'h7000_0001);
      push(32'h7000_0002);
      push(32'h7000_0003);
      tx_busy = 1'b0;
      wait_send(c);
      tx_busy = 1'b1;
      tick();
      tick();
      check("t6_count_pre", {29'd0, queue_count}, 32'd2);
      #2 rst = 1'b1;
      #1;
      check("t6_async_count", {29'd0, queue_count}, 32'd0);
      check("t6_async_empty", {31'd0, queue_empty}, 32'd1);
      check("t6_async_word", tx_word, 32'd0);
      check("t6_async_ovf", {24'd0, overflow_cnt}, 32'd0);
      check("t6_async_send", {31'd0, tx_send}, 32'd0);
      #10 rst = 1'b0;
      tick();

      // 6b: overflow counter saturation, then push+pop at full
      for (int i = 1; i <= 4; i++) push(32'h4000_0000 + i);
      for (int i = 0; i < 300; i++) push(32'h5000_0000 + i);
      check("t6_sat", {24'd0, overflow_cnt}, 32'd255);
      check("t6_full", {29'd0, queue_count}, 32'd4);
      tx_busy     = 1'b0;
      nonce_valid = 1'b1;
      nonce_in    = 32'h6000_0000;
      tick();
      nonce_valid = 1'b0;
      check("t6_pushpop_count", {29'd0, queue_count}, 32'd4);
      check("t6_pushpop_ovf", {24'd0, overflow_cnt}, 32'd255);
      check("t6_pushpop_send", {31'd0, tx_send}, 32'd1);
      check("t6_pushpop_word", tx_word, 32'h4000_0001);
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
